cpu_run_ctrl: RTL and testbench

Run/step/halt controller for the single-cycle CPU.
- Produces `cpu_en`, the per-cycle enable for all architectural state updates (PC, register bank writes, memory writes).
- Supports free-run, single-step, run-N-instructions and a PC breakpoint.
- Shares the register bank read port with a debug requester while the CPU is halted.
- Sits between the CPU top level and the bench/debug host.

---
 rtl/cpu_run_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller: gates CPU commits, counts retired instructions, stops on a
// PC breakpoint and lends the register bank read port to a debug reader while halted.
// Optional build macro RUN_ON_RESET_EN: leave reset free-running instead of halted.
module cpu_run_ctrl #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 10,
  parameter int RA_W  = 4,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [PC_W-1:0]  pc,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             cpu_en,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] retired,
  input  logic             dbg_req,
  input  logic [RA_W-1:0]  dbg_addr,
  output logic             dbg_gnt,
  output logic [DW-1:0]    dbg_data,
  output logic             rb_sel,
  output logic [RA_W-1:0]  rb_raddr,
  input  logic [DW-1:0]    rb_rdata
);

  localparam logic [2:0] ST_HALT = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_STEP = 3'd2;
  localparam logic [2:0] ST_RUNN = 3'd3;
  localparam logic [2:0] ST_DBG  = 3'd4;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef RUN_ON_RESET_EN
  localparam logic [2:0] RST_STATE = ST_RUN;
`else
  localparam logic [2:0] RST_STATE = ST_HALT;
`endif

  logic [2:0]       state_q, state_d;
  logic             first_q, first_d;
  logic             bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [RA_W-1:0]  dbg_addr_q, dbg_addr_d;
  logic             dbg_gnt_q, dbg_gnt_d;
  logic [DW-1:0]    dbg_data_q, dbg_data_d;

  logic active, bp_stop, cmd_acc;

  assign active    = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_RUNN);
  // The first cycle after any command ignores the breakpoint so a resume executes it.
  assign bp_stop   = bp_en && (pc == bp_addr) && !first_q && (state_q != ST_STEP);
  assign cpu_en    = active && !bp_stop && !reset;
  assign cmd_ready = (state_q != ST_DBG);
  assign cmd_acc   = cmd_valid && cmd_ready;

  assign halted    = !active;
  assign bp_hit    = bp_hit_q;
  assign retired   = retired_q;
  assign dbg_gnt   = dbg_gnt_q;
  assign dbg_data  = dbg_data_q;
  assign rb_sel    = (state_q == ST_DBG);
  assign rb_raddr  = dbg_addr_q;

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    bp_hit_d   = bp_hit_q;
    rem_d      = rem_q;
    dbg_addr_d = dbg_addr_q;
    dbg_gnt_d  = 1'b0;
    dbg_data_d = dbg_data_q;
    retired_d  = retired_q + {{(CNT_W-1){1'b0}}, cpu_en};
    if (active) first_d = 1'b0;

    if (cmd_acc) begin
      bp_hit_d = 1'b0;
      first_d  = 1'b1;
      case (cmd_op)
        OP_RUN:  state_d = ST_RUN;
        OP_HALT: begin
          state_d = ST_HALT;
          rem_d   = '0;
        end
        OP_STEP: state_d = ST_STEP;
        default: begin
          if (cmd_count == '0) begin
            state_d = ST_HALT;
            rem_d   = '0;
          end else begin
            state_d = ST_RUNN;
            rem_d   = cmd_count;
          end
        end
      endcase
    end else begin
      case (state_q)
        ST_HALT: begin
          if (dbg_req) begin
            state_d    = ST_DBG;
            dbg_addr_d = dbg_addr;
          end
        end
        ST_RUN: begin
          if (bp_stop) begin
            state_d  = ST_HALT;
            bp_hit_d = 1'b1;
            rem_d    = '0;
          end
        end
        ST_STEP: state_d = ST_HALT;
        ST_RUNN: begin
          if (bp_stop) begin
            state_d  = ST_HALT;
            bp_hit_d = 1'b1;
            rem_d    = '0;
          end else if (cpu_en && (rem_q != '0)) begin
            rem_d = rem_q - ONE;
            if (rem_q == ONE) state_d = ST_HALT;
          end
        end
        ST_DBG: begin
          state_d    = ST_HALT;
          dbg_gnt_d  = 1'b1;
          dbg_data_d = rb_rdata;
        end
        default: state_d = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RST_STATE;
      first_q    <= 1'b1;
      bp_hit_q   <= 1'b0;
      rem_q      <= '0;
      retired_q  <= '0;
      dbg_addr_q <= '0;
      dbg_gnt_q  <= 1'b0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      bp_hit_q   <= bp_hit_d;
      rem_q      <= rem_d;
      retired_q  <= retired_d;
      dbg_addr_q <= dbg_addr_d;
      dbg_gnt_q  <= dbg_gnt_d;
      dbg_data_q <= dbg_data_d;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: command vector table, breakpoint, debug-read
// scoreboard and asynchronous reset sequences.
module tb_cpu_run_ctrl;
  localparam int CNT_W = 16;
  localparam int PC_W  = 10;
  localparam int RA_W  = 4;
  localparam int DW    = 8;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_RUNN = 2'b11;

`ifdef RUN_ON_RESET_EN
  localparam logic RST_HALTED = 1'b0;
`else
  localparam logic RST_HALTED = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [PC_W-1:0]  pc = '0;
  logic             pc_clr = 1'b0;
  logic             bp_en = 1'b0;
  logic [PC_W-1:0]  bp_addr = '0;
  logic             cpu_en;
  logic             halted;
  logic             bp_hit;
  logic [CNT_W-1:0] retired;
  logic             dbg_req = 1'b0;
  logic [RA_W-1:0]  dbg_addr = '0;
  logic             dbg_gnt;
  logic [DW-1:0]    dbg_data;
  logic             rb_sel;
  logic [RA_W-1:0]  rb_raddr;
  logic [DW-1:0]    rb_rdata;

  logic [DW-1:0] regb [16];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;

  int checks = 0;
  int errors = 0;

  cpu_run_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W), .RA_W(RA_W), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
    .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .cpu_en(cpu_en), .halted(halted), .bp_hit(bp_hit), .retired(retired),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_data(dbg_data),
    .rb_sel(rb_sel), .rb_raddr(rb_raddr), .rb_rdata(rb_rdata)
  );

  always #5 clk = ~clk;

  // Minimal CPU model: the PC advances only on committed cycles.
  always @(posedge clk) begin
    if (pc_clr) pc <= '0;
    else if (cpu_en) pc <= pc + PC_W'(1);
  end

  assign rb_rdata = regb[rb_raddr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Grant monitor: every grant pops the value queued when the request was driven.
  always @(negedge clk) begin
    if (dbg_gnt === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dbg_gnt", 1, int'(exp_q.size()));
      end else begin
        mon_exp = exp_q.pop_front();
        chk("dbg_data_scoreboard", int'(dbg_data), int'(mon_exp));
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
    chk("cmd_ready_at_send", int'(cmd_ready), 1);
    cmd_op    = op;
    cmd_count = cnt;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic after_reset();
`ifdef RUN_ON_RESET_EN
    chk("run_on_reset_cpu_en", int'(cpu_en), 1);
    chk("run_on_reset_halted", int'(halted), 0);
    send(OP_HALT, '0);
`endif
  endtask

  task automatic wait_gnt(input int maxc, output int n);
    n = 0;
    while (dbg_gnt !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("dbg_gnt_seen", int'(dbg_gnt), 1);
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [CNT_W-1:0] cnt;
    int               pulses;
    int               ret_cum;
  } vec_t;

  vec_t vt [7];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n_en, first_i, last_i, n, ngnt;
    logic [CNT_W-1:0] base;
    logic ex_at_bp;

    vt[0] = '{OP_STEP, 16'd0, 1, 1};
    vt[1] = '{OP_STEP, 16'd0, 1, 2};
    vt[2] = '{OP_STEP, 16'd0, 1, 3};
    vt[3] = '{OP_RUNN, 16'd5, 5, 8};
    vt[4] = '{OP_RUNN, 16'd0, 0, 8};
    vt[5] = '{OP_RUNN, 16'd1, 1, 9};
    vt[6] = '{OP_HALT, 16'd0, 0, 9};

    for (int i = 0; i < 16; i++) regb[i] = DW'(i * 3);
    regb[2] = 8'd7;
    regb[5] = 8'hA5;

    // Reset then idle
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    after_reset();
    repeat (5) @(negedge clk);
    chk("rst_halted", int'(halted), 1);
    chk("rst_cpu_en", int'(cpu_en), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_bp_hit", int'(bp_hit), 0);
    chk("rst_rb_sel", int'(rb_sel), 0);
    chk("rst_rb_raddr", int'(rb_raddr), 0);
    chk("rst_dbg_gnt", int'(dbg_gnt), 0);
    chk("rst_dbg_data", int'(dbg_data), 0);
`ifndef RUN_ON_RESET_EN
    chk("rst_retired", int'(retired), 0);
`endif

    // Command vector table
    base = retired;
    for (int v = 0; v < 7; v++) begin
      send(vt[v].op, vt[v].cnt);
      n_en = 0; first_i = -1; last_i = -1;
      for (int c = 0; c < 20; c++) begin
        if (cpu_en) begin
          n_en++;
          if (first_i < 0) first_i = c;
          last_i = c;
        end
        @(negedge clk);
      end
      chk($sformatf("vec%0d_pulses", v), n_en, vt[v].pulses);
      chk($sformatf("vec%0d_first_cycle", v), first_i, (vt[v].pulses > 0) ? 0 : -1);
      chk($sformatf("vec%0d_last_cycle", v), last_i, vt[v].pulses - 1);
      chk($sformatf("vec%0d_retired", v), int'(CNT_W'(retired - base)), vt[v].ret_cum);
      chk($sformatf("vec%0d_halted", v), int'(halted), 1);
    end

    // Breakpoint stop and resume
    pc_clr = 1'b1;
    @(negedge clk);
    pc_clr  = 1'b0;
    bp_en   = 1'b1;
    bp_addr = PC_W'(4);
    base    = retired;
    send(OP_RUN, '0);
    ex_at_bp = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (cpu_en && pc == PC_W'(4)) ex_at_bp = 1'b1;
      @(negedge clk);
    end
    chk("bp_not_executed", int'(ex_at_bp), 0);
    chk("bp_halted", int'(halted), 1);
    chk("bp_hit_set", int'(bp_hit), 1);
    chk("bp_pc", int'(pc), 4);
    chk("bp_retired", int'(CNT_W'(retired - base)), 4);
    send(OP_RUN, '0);
    chk("resume_bp_hit_clr", int'(bp_hit), 0);
    chk("resume_cpu_en", int'(cpu_en), 1);
    chk("resume_pc", int'(pc), 4);
    repeat (3) @(negedge clk);
    chk("resume_pc_adv", int'(pc), 7);
    chk("resume_running", int'(halted), 0);
    send(OP_HALT, '0);
    chk("halt_cmd_halted", int'(halted), 1);
    chk("halt_cmd_cpu_en", int'(cpu_en), 0);
    bp_en = 1'b0;

    // Debug read while halted
    dbg_addr = 4'd2;
    dbg_req  = 1'b1;
    exp_q.push_back(8'd7);
    @(negedge clk);
    chk("dbg_rb_sel", int'(rb_sel), 1);
    chk("dbg_rb_raddr", int'(rb_raddr), 2);
    chk("dbg_cmd_ready", int'(cmd_ready), 0);
    chk("dbg_gnt_early", int'(dbg_gnt), 0);
    @(negedge clk);
    chk("dbg_gnt_k2", int'(dbg_gnt), 1);
    chk("dbg_rb_sel_off", int'(rb_sel), 0);
    dbg_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("dbg_gnt_pulse", int'(dbg_gnt), 0);
    chk("dbg_data_hold", int'(dbg_data), 7);

    // STEP and dbg_req on the same edge: command first
    cmd_op    = OP_STEP;
    cmd_valid = 1'b1;
    dbg_addr  = 4'd5;
    dbg_req   = 1'b1;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("step_dbg_cpu_en", int'(cpu_en), 1);
    chk("step_dbg_rb_sel", int'(rb_sel), 0);
    wait_gnt(8, n);
    chk("step_dbg_latency", n, 3);
    dbg_req = 1'b0;
    @(negedge clk);
    chk("step_dbg_data_hold", int'(dbg_data), 8'hA5);

    // Reset in the middle of RUN_N
    send(OP_RUNN, 16'd5);
    repeat (2) @(negedge clk);
    chk("runn_mid_cpu_en", int'(cpu_en), 1);
    reset = 1'b1;
    #1;
    chk("rst_runn_cpu_en", int'(cpu_en), 0);
    chk("rst_runn_rb_sel", int'(rb_sel), 0);
    chk("rst_runn_retired", int'(retired), 0);
    chk("rst_runn_halted", int'(halted), int'(RST_HALTED));
    @(negedge clk);
    reset = 1'b0;
    after_reset();
    n_en = 0;
    for (int c = 0; c < 6; c++) begin
      if (cpu_en) n_en++;
      @(negedge clk);
    end
    chk("rst_runn_no_resume", n_en, 0);

    // Reset while the debug read is in flight
    dbg_addr = 4'd2;
    dbg_req  = 1'b1;
    exp_q.push_back(8'd7);
    @(negedge clk);
    chk("dbg2_rb_sel", int'(rb_sel), 1);
    reset = 1'b1;
    #1;
    chk("rst_dbg_rb_sel", int'(rb_sel), 0);
    chk("rst_dbg_gnt", int'(dbg_gnt), 0);
    chk("rst_dbg_data_clr", int'(dbg_data), 0);
    exp_q.delete();
    dbg_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    after_reset();
    ngnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (dbg_gnt) ngnt++;
      @(negedge clk);
    end
    chk("rst_dbg_no_gnt", ngnt, 0);

    chk("scoreboard_drained", int'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
